match_collector: RTL and testbench

MATCH_COLLECTOR -- requirements
Module: match_collector

---
 rtl/match_collector.sv | 148 ++++++++++++++
 tb/tb_match_collector.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/match_collector.sv
// Collects set lanes of PE result vectors into (weight index, string position) records
// and buffers them in a small FIFO; acks each weight batch once all its records drain.
module match_collector #(
  parameter int max_number_of_weight = 16,
  parameter int POS_W                = 8,
  parameter int IDX_W                = 16,
  parameter int FIFO_DEPTH           = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [max_number_of_weight-1:0] in_result,
  input  logic [POS_W-1:0]                in_pos,
  input  logic [IDX_W-1:0]                in_base,
  input  logic                            in_last,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [IDX_W-1:0]                out_idx,
  output logic [POS_W-1:0]                out_pos,
  output logic [15:0]                     match_count,
  output logic                            batch_ack,
  output logic                            overflow
);

  localparam int NL     = max_number_of_weight;
  localparam int LANE_W = (NL > 1) ? $clog2(NL) : 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_e;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [POS_W-1:0] pos;
  } rec_t;

  state_e           state_q, state_d;
  logic [NL-1:0]    vec_q, vec_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [IDX_W-1:0] base_q, base_d;
  logic             last_q, last_d;

  rec_t             mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] cnt_q;
  logic [15:0]      match_q;
  logic             ovf_q;

  logic [LANE_W-1:0] lane;
  logic [NL-1:0]     lane_oh;
  logic              full, push, pop, accept;
  rec_t              rec;

  // Lowest set lane wins: scanning downward lets the lowest index overwrite last.
  always_comb begin
    lane    = '0;
    lane_oh = '0;
    for (int k = NL - 1; k >= 0; k--) begin
      if (vec_q[k]) lane = LANE_W'(k);
    end
    lane_oh[lane] = 1'b1;
  end

  assign full    = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign push    = (state_q == SCAN) && !full && (|vec_q);
  assign pop     = (cnt_q != '0) && out_ready;
  assign accept  = in_valid && in_ready;
  assign rec.idx = base_q + IDX_W'(lane);
  assign rec.pos = pos_q;

  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    pos_d     = pos_q;
    base_d    = base_q;
    last_d    = last_q;
    in_ready  = (state_q == IDLE);
    batch_ack = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          vec_d  = in_result;
          pos_d  = in_pos;
          base_d = in_base;
          last_d = in_last;
          if (|in_result)   state_d = SCAN;
          else if (in_last) state_d = DRAIN;
        end
      end
      SCAN: begin
        if (push) begin
          vec_d = vec_q & ~lane_oh;
          if (vec_d == '0) state_d = last_q ? DRAIN : IDLE;
        end
      end
      DRAIN: begin
        if (cnt_q == '0) begin
          batch_ack = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      vec_q   <= '0;
      pos_q   <= '0;
      base_q  <= '0;
      last_q  <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      match_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      pos_q   <= pos_d;
      base_q  <= base_d;
      last_q  <= last_d;
      if (push) wr_q <= wr_q + PTR_W'(1);
      if (pop)  rd_q <= rd_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (push && match_q != 16'hFFFF) match_q <= match_q + 16'd1;
      ovf_q <= ovf_q | (push && full);
    end
  end

  // Storage needs no reset: outputs are masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= rec;
  end

  assign out_valid   = (cnt_q != '0);
  assign out_idx     = out_valid ? mem_q[rd_q].idx : '0;
  assign out_pos     = out_valid ? mem_q[rd_q].pos : '0;
  assign match_count = match_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_match_collector.sv
// Directed bench for match_collector: one task per scenario with inline checks.
module tb_match_collector;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_result = '0;
  logic [7:0]  in_pos = '0;
  logic [15:0] in_base = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_idx;
  logic [7:0]  out_pos;
  logic [15:0] match_count;
  logic        batch_ack;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  match_collector dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_pos(in_pos), .in_base(in_base), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx), .out_pos(out_pos),
    .match_count(match_count), .batch_ack(batch_ack), .overflow(overflow)
  );

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Presents one vector; returns 1 ns after the accepting edge.
  task automatic send(input logic [15:0] r, input logic [15:0] b, input logic [7:0] p,
                      input logic l);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_wait: in_ready=%0b required=1 after %0d cycles", in_ready, n);
    end
    in_valid = 1'b1; in_result = r; in_base = b; in_pos = p; in_last = l;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || match_count !== 16'd0 ||
        batch_ack !== 1'b0 || overflow !== 1'b0 || out_idx !== 16'd0 || out_pos !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: rdy=%0b ov=%0b mc=%0d ack=%0b ovf=%0b idx=%0h pos=%0h required 1 0 0 0 0 0 0",
               in_ready, out_valid, match_count, batch_ack, overflow, out_idx, out_pos);
    end
  endtask

  task automatic test_single();
    do_reset();
    out_ready = 1'b1;
    send(16'h8001, 16'd100, 8'd5, 1'b0);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_scan1: out_valid=%0b in_ready=%0b required 0 0", out_valid, in_ready);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 16'd100 || out_pos !== 8'd5) begin
      errors++;
      $display("FAIL single_rec0: v=%0b idx=%0d pos=%0d required 1 100 5", out_valid, out_idx, out_pos);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 16'd115 || out_pos !== 8'd5 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_rec1: v=%0b idx=%0d pos=%0d rdy=%0b required 1 115 5 1",
               out_valid, out_idx, out_pos, in_ready);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || match_count !== 16'd2 || batch_ack !== 1'b0) begin
      errors++;
      $display("FAIL single_end: v=%0b mc=%0d ack=%0b required 0 2 0", out_valid, match_count, batch_ack);
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    int guard = 0;
    do_reset();
    out_ready = 1'b0;
    send(16'hFFFF, 16'h0200, 8'd9, 1'b0);
    repeat (12) @(negedge clk);
    checks++;
    if (match_count !== 16'd8 || out_valid !== 1'b1 || in_ready !== 1'b0 ||
        overflow !== 1'b0 || out_idx !== 16'h0200) begin
      errors++;
      $display("FAIL bp_stall: mc=%0d v=%0b rdy=%0b ovf=%0b idx=%0h required 8 1 0 0 200",
               match_count, out_valid, in_ready, overflow, out_idx);
    end
    out_ready = 1'b1;
    while (n < 16 && guard < 100) begin
      if (out_valid) begin
        checks++;
        if (out_idx !== 16'h0200 + 16'(n) || out_pos !== 8'd9) begin
          errors++;
          $display("FAIL bp_rec%0d: idx=%0h pos=%0d required %0h 9", n, out_idx, out_pos, 16'h0200 + 16'(n));
        end
        n++;
      end
      @(negedge clk);
      guard++;
    end
    checks++;
    if (n != 16 || out_valid !== 1'b0 || match_count !== 16'd16 || overflow !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_end: recs=%0d v=%0b mc=%0d ovf=%0b rdy=%0b required 16 0 16 0 1",
               n, out_valid, match_count, overflow, in_ready);
    end
  endtask

  task automatic test_zero_last();
    int acks = 0;
    do_reset();
    out_ready = 1'b1;
    send(16'h0000, 16'd7, 8'd1, 1'b1);
    @(negedge clk);
    checks++;
    if (batch_ack !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL zl_ack: ack=%0b v=%0b rdy=%0b required 1 0 0", batch_ack, out_valid, in_ready);
    end
    acks = 1;
    repeat (6) begin
      @(negedge clk);
      if (batch_ack) acks++;
    end
    checks++;
    if (acks != 1 || match_count !== 16'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL zl_once: acks=%0d mc=%0d rdy=%0b required 1 0 1", acks, match_count, in_ready);
    end
  endtask

  task automatic test_last_batch();
    int acks = 0;
    do_reset();
    out_ready = 1'b1;
    send(16'h0010, 16'd40, 8'd2, 1'b1);
    repeat (8) begin
      @(negedge clk);
      if (batch_ack) acks++;
    end
    checks++;
    if (acks != 1 || match_count !== 16'd1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL last_batch: acks=%0d mc=%0d rdy=%0b required 1 1 1", acks, match_count, in_ready);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] exp_idx [2];
    int n = 0;
    int guard = 0;
    exp_idx[0] = 16'hFFFF;
    exp_idx[1] = 16'h0000;
    do_reset();
    out_ready = 1'b1;
    send(16'h0006, 16'hFFFE, 8'd3, 1'b0);
    while (n < 2 && guard < 20) begin
      @(negedge clk);
      guard++;
      if (out_valid) begin
        checks++;
        if (out_idx !== exp_idx[n] || out_pos !== 8'd3) begin
          errors++;
          $display("FAIL wrap_rec%0d: idx=%0h pos=%0d required %0h 3", n, out_idx, out_pos, exp_idx[n]);
        end
        n++;
      end
    end
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL wrap_count: records=%0d required 2", n);
    end
  endtask

  task automatic test_reset_mid_scan();
    int acks = 0;
    do_reset();
    out_ready = 1'b0;
    send(16'hFFFF, 16'd0, 8'd4, 1'b1);
    repeat (2) @(posedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || match_count !== 16'd0 || batch_ack !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rms_state: v=%0b mc=%0d ack=%0b rdy=%0b required 0 0 0 1",
               out_valid, match_count, batch_ack, in_ready);
    end
    repeat (20) begin
      @(negedge clk);
      if (batch_ack || out_valid) acks++;
    end
    checks++;
    if (acks != 0) begin
      errors++;
      $display("FAIL rms_quiet: ack_or_valid_cycles=%0d required 0", acks);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4095; i++) send(16'hFFFF, 16'd0, 8'd0, 1'b0);
    repeat (20) @(negedge clk);
    checks++;
    if (match_count !== 16'd65520) begin
      errors++;
      $display("FAIL sat_pre: match_count=%0d required 65520", match_count);
    end
    for (int i = 0; i < 2; i++) send(16'hFFFF, 16'd0, 8'd0, 1'b0);
    repeat (20) @(negedge clk);
    checks++;
    if (match_count !== 16'hFFFF || overflow !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL sat_hold: mc=%0h ovf=%0b v=%0b required ffff 0 0", match_count, overflow, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_zero_last();
    test_last_batch();
    test_wrap();
    test_reset_mid_scan();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
